// File: rtl/cpu_pkg.sv
// Shared PANDA CPU definitions: fetch FSM encoding and fetch-stage constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [8:0] HALT_INSTR_DEFAULT = 9'h1FF;
    localparam int unsigned FETCH_CNT_WIDTH = 16;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready handshake carrying the instruction word and its PC.
interface fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned INSTR_WIDTH = 9
);
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0]  out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM address, one-entry output register, HALT detection
// and a saturating count of delivered instructions.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = 12,
    parameter int unsigned            INSTR_WIDTH = 9,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = INSTR_WIDTH'(HALT_INSTR_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      start_addr,
    output logic [ADDR_WIDTH-1:0]      instr_addr,
    input  logic [INSTR_WIDTH-1:0]     instr_in,
    input  logic                       redirect_valid,
    input  logic [ADDR_WIDTH-1:0]      redirect_target,
    fetch_unit_if.master               dec,
    output logic                       done,
    output logic [FETCH_CNT_WIDTH-1:0] fetch_count
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  handshake;
    logic                  load;
    logic                  restart;

    assign instr_addr = pc;
    assign handshake  = dec.out_valid && dec.out_ready;
    assign load       = !dec.out_valid || dec.out_ready;
    assign restart    = start && (state != FETCH);
    assign done       = (state == HALTED) && !dec.out_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= '0;
            dec.out_valid <= 1'b0;
            dec.out_instr <= '0;
            dec.out_pc    <= '0;
            fetch_count   <= '0;
        end else begin
            // A start from IDLE/HALTED takes priority over a handshake in the same cycle.
            if (restart) begin
                fetch_count <= '0;
            end else if (handshake && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 1'b1;
            end

            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        pc            <= start_addr;
                        dec.out_valid <= 1'b0;
                        state         <= FETCH;
                    end else if (handshake) begin
                        dec.out_valid <= 1'b0;
                    end
                end
                FETCH: begin
                    if (redirect_valid) begin
                        pc            <= redirect_target;
                        dec.out_valid <= 1'b0;
                    end else if (load) begin
                        dec.out_instr <= instr_in;
                        dec.out_pc    <= pc;
                        dec.out_valid <= 1'b1;
                        if (instr_in == HALT_INSTR) begin
                            state <= HALTED;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a behavioural ROM.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] start_addr = '0;
    logic [11:0] instr_addr;
    logic [8:0]  instr_in;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_target = '0;
    logic        done;
    logic [15:0] fetch_count;

    logic [8:0] rom [4096];

    int unsigned errors = 0;
    int unsigned checks = 0;

    fetch_unit_if #(.ADDR_WIDTH(12), .INSTR_WIDTH(9)) dec_if ();

    fetch_unit #(.ADDR_WIDTH(12), .INSTR_WIDTH(9), .HALT_INSTR(9'h1FF)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .start_addr      (start_addr),
        .instr_addr      (instr_addr),
        .instr_in        (instr_in),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .dec             (dec_if.master),
        .done            (done),
        .fetch_count     (fetch_count)
    );

    assign instr_in = rom[instr_addr];

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [11:0] sa;
        logic        rv;
        logic [11:0] rt;
        logic        rdy;
        logic        e_valid;
        logic [8:0]  e_instr;
        logic [11:0] e_pc;
        logic [11:0] e_addr;
        logic        e_done;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [8:0] ei,
                                 input logic [11:0] ep, input logic [11:0] ea,
                                 input logic ed, input logic [15:0] ec, input logic cmp_word);
        check({tag, ".out_valid"}, 32'(dec_if.out_valid), 32'(ev));
        if (cmp_word) begin
            check({tag, ".out_instr"}, 32'(dec_if.out_instr), 32'(ei));
            check({tag, ".out_pc"}, 32'(dec_if.out_pc), 32'(ep));
        end
        check({tag, ".instr_addr"}, 32'(instr_addr), 32'(ea));
        check({tag, ".done"}, 32'(done), 32'(ed));
        check({tag, ".fetch_count"}, 32'(fetch_count), 32'(ec));
    endtask

    // Drive one cycle of inputs, clock once, then compare just after the edge.
    task automatic step(input string tag, input vec_t v);
        start           = v.st;
        start_addr      = v.sa;
        redirect_valid  = v.rv;
        redirect_target = v.rt;
        dec_if.out_ready = v.rdy;
        @(posedge clk);
        #1;
        check_outputs(tag, v.e_valid, v.e_instr, v.e_pc, v.e_addr, v.e_done, v.e_cnt, v.e_valid);
    endtask

    function automatic vec_t mk(input logic st, input logic [11:0] sa, input logic rv,
                                input logic [11:0] rt, input logic rdy, input logic ev,
                                input logic [8:0] ei, input logic [11:0] ep, input logic [11:0] ea,
                                input logic ed, input logic [15:0] ec);
        vec_t v;
        v.st = st; v.sa = sa; v.rv = rv; v.rt = rt; v.rdy = rdy;
        v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_addr = ea; v.e_done = ed; v.e_cnt = ec;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0;
        redirect_valid = 1'b0;
        dec_if.out_ready = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        dec_if.out_ready = 1'b0;
        for (int i = 0; i < 4096; i++) rom[i] = {1'b0, 8'(i)};
        rom[0] = 9'h011; rom[1] = 9'h022; rom[2] = 9'h033; rom[12'h100] = 9'h0AA;

        //         st sa      rv rt      rdy v  instr   pc      addr    d  cnt
        vecs[0]  = mk(1, 12'h000, 0, 12'h000, 1, 0, 9'h000, 12'h000, 12'h000, 0, 16'd0);
        vecs[1]  = mk(0, 12'h000, 0, 12'h000, 1, 1, 9'h011, 12'h000, 12'h001, 0, 16'd0);
        vecs[2]  = mk(0, 12'h000, 0, 12'h000, 0, 1, 9'h011, 12'h000, 12'h001, 0, 16'd0);
        vecs[3]  = mk(0, 12'h000, 0, 12'h000, 0, 1, 9'h011, 12'h000, 12'h001, 0, 16'd0);
        vecs[4]  = mk(0, 12'h000, 0, 12'h000, 0, 1, 9'h011, 12'h000, 12'h001, 0, 16'd0);
        vecs[5]  = mk(0, 12'h000, 0, 12'h000, 1, 1, 9'h022, 12'h001, 12'h002, 0, 16'd1);
        vecs[6]  = mk(0, 12'h000, 0, 12'h000, 1, 1, 9'h033, 12'h002, 12'h003, 0, 16'd2);
        vecs[7]  = mk(0, 12'h000, 1, 12'h100, 1, 0, 9'h000, 12'h000, 12'h100, 0, 16'd3);
        vecs[8]  = mk(0, 12'h000, 0, 12'h000, 1, 1, 9'h0AA, 12'h100, 12'h101, 0, 16'd3);
        vecs[9]  = mk(0, 12'h000, 0, 12'h000, 1, 1, 9'h001, 12'h101, 12'h102, 0, 16'd4);
        vecs[10] = mk(0, 12'h000, 1, 12'h100, 0, 0, 9'h000, 12'h000, 12'h100, 0, 16'd4);
        vecs[11] = mk(1, 12'h800, 0, 12'h000, 1, 1, 9'h0AA, 12'h100, 12'h101, 0, 16'd4);
        vecs[12] = mk(0, 12'h000, 0, 12'h000, 1, 1, 9'h001, 12'h101, 12'h102, 0, 16'd5);

        #1 reset = 1'b1;
        #11 reset = 1'b0;
        check_outputs("reset", 1'b0, 9'h000, 12'h000, 12'h000, 1'b0, 16'd0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 13; i++) step($sformatf("vec%0d", i), vecs[i]);

        // PC wraps from the top of the address space to zero.
        do_reset();
        step("wrap0", mk(1, 12'hFFF, 0, 12'h000, 1, 0, 9'h000, 12'h000, 12'hFFF, 0, 16'd0));
        step("wrap1", mk(0, 12'h000, 0, 12'h000, 1, 1, 9'h0FF, 12'hFFF, 12'h000, 0, 16'd0));
        step("wrap2", mk(0, 12'h000, 0, 12'h000, 1, 1, 9'h011, 12'h000, 12'h001, 0, 16'd1));

        // HALT: emitted once, drains, done, redirect ignored, start restarts.
        do_reset();
        rom[5] = 9'h1FF;
        step("halt0", mk(1, 12'h003, 0, 12'h000, 1, 0, 9'h000, 12'h000, 12'h003, 0, 16'd0));
        step("halt1", mk(0, 12'h000, 0, 12'h000, 1, 1, 9'h003, 12'h003, 12'h004, 0, 16'd0));
        step("halt2", mk(0, 12'h000, 0, 12'h000, 1, 1, 9'h004, 12'h004, 12'h005, 0, 16'd1));
        step("halt3", mk(0, 12'h000, 0, 12'h000, 1, 1, 9'h1FF, 12'h005, 12'h005, 0, 16'd2));
        step("halt4", mk(0, 12'h000, 0, 12'h000, 0, 1, 9'h1FF, 12'h005, 12'h005, 0, 16'd2));
        step("halt5", mk(0, 12'h000, 0, 12'h000, 1, 0, 9'h000, 12'h000, 12'h005, 1, 16'd3));
        step("halt6", mk(0, 12'h000, 0, 12'h000, 1, 0, 9'h000, 12'h000, 12'h005, 1, 16'd3));
        step("halt7", mk(0, 12'h000, 1, 12'h100, 1, 0, 9'h000, 12'h000, 12'h005, 1, 16'd3));
        step("halt8", mk(1, 12'h000, 0, 12'h000, 1, 0, 9'h000, 12'h000, 12'h000, 0, 16'd0));
        step("halt9", mk(0, 12'h000, 0, 12'h000, 1, 1, 9'h011, 12'h000, 12'h001, 0, 16'd0));
        step("halt10", mk(0, 12'h000, 0, 12'h000, 1, 1, 9'h022, 12'h001, 12'h002, 0, 16'd1));

        // Asynchronous reset mid-stream, checked between clock edges.
        #3;
        reset = 1'b1;
        #1;
        check_outputs("async_rst", 1'b0, 9'h000, 12'h000, 12'h000, 1'b0, 16'd0, 1'b1);
        #2;
        reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
